// File: rtl/crom_loader.sv
// Coefficient RAM writer: assembles COEF_WIDTH-bit words from an MSB-first byte stream and
// writes them to sequential addresses 0..TAPS-1, then flags the table as loaded.
module crom_loader #(
    parameter int unsigned COEF_WIDTH = 24,
    parameter int unsigned TAPS       = 256,
    parameter int unsigned MAX_ADR    = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         load_start,
    input  logic                         byte_valid,
    input  logic [7:0]                   byte_data,
    output logic                         byte_ready,
    output logic                         wr_en,
    output logic [MAX_ADR-1:0]           wr_addr,
    output logic signed [COEF_WIDTH-1:0] wr_data,
    output logic                         busy,
    output logic                         loaded,
    output logic                         done
);

    localparam int unsigned BYTES = COEF_WIDTH / 8;
    localparam int unsigned BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [BCW-1:0]     LAST_BYTE = BCW'(BYTES - 1);
    localparam logic [MAX_ADR-1:0] LAST_WORD = MAX_ADR'(TAPS - 1);

    typedef enum logic [0:0] {StIdle, StLoad} state_e;

    state_e                  state_q, state_d;
    logic [BCW-1:0]          byte_cnt_q, byte_cnt_d;
    logic [MAX_ADR-1:0]      word_cnt_q, word_cnt_d;
    logic [COEF_WIDTH-1:0]   shift_q, shift_d, shift_next;
    logic                    wr_en_q, wr_en_d;
    logic [MAX_ADR-1:0]      wr_addr_q, wr_addr_d;
    logic [COEF_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic                    loaded_q, loaded_d;
    logic                    done_q, done_d;
    logic                    accept;

    assign accept     = byte_valid && (state_q == StLoad);
    // Oldest byte falls off the top; the final byte of a word completes it in place.
    assign shift_next = COEF_WIDTH'({shift_q, byte_data});

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        shift_d    = shift_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        loaded_d   = loaded_q;
        done_d     = 1'b0;

        case (state_q)
            StIdle: begin
                if (load_start) begin
                    state_d    = StLoad;
                    byte_cnt_d = '0;
                    word_cnt_d = '0;
                    shift_d    = '0;
                    loaded_d   = 1'b0;
                end
            end
            StLoad: begin
                // Restart beats any byte arriving in the same cycle, including the last one.
                if (load_start) begin
                    byte_cnt_d = '0;
                    word_cnt_d = '0;
                    shift_d    = '0;
                end else if (accept) begin
                    shift_d = shift_next;
                    if (byte_cnt_q == LAST_BYTE) begin
                        byte_cnt_d = '0;
                        wr_en_d    = 1'b1;
                        wr_addr_d  = word_cnt_q;
                        wr_data_d  = shift_next;
                        word_cnt_d = word_cnt_q + MAX_ADR'(1);
                        if (word_cnt_q == LAST_WORD) begin
                            state_d    = StIdle;
                            word_cnt_d = '0;
                            done_d     = 1'b1;
                            loaded_d   = 1'b1;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + BCW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            shift_q    <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            loaded_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
            shift_q    <= shift_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            loaded_q   <= loaded_d;
            done_q     <= done_d;
        end
    end

    assign byte_ready = (state_q == StLoad);
    assign busy       = (state_q == StLoad);
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign loaded     = loaded_q;
    assign done       = done_q;

endmodule
